// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. RV32I loads/stores over a byte-serial
// synchronous RAM (one-cycle read latency), stalling the pipe meanwhile.
// Ports: clk_in, rst_in (sync, active-low), rdy_in (low = pause).
//   ex_mem side : rd_we_in, rd_addr_in, rd_val_in, mem_re_in, mem_we_in,
//                 funct3_in, mem_addr_in, store_data_in
//   RAM side    : mem_din (byte for address issued last active cycle),
//                 mem_a_out, mem_wr_out, mem_dout
//   mem_wb side : rd_we_out, rd_addr_out, rd_val_out
//   control     : stall_req_out
module mem_access #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              rd_we_in,
   input  logic [4:0]        rd_addr_in,
   input  logic [XLEN-1:0]   rd_val_in,
   input  logic              mem_re_in,
   input  logic              mem_we_in,
   input  logic [2:0]        funct3_in,
   input  logic [ADDR_W-1:0] mem_addr_in,
   input  logic [XLEN-1:0]   store_data_in,
   input  logic [7:0]        mem_din,
   output logic [ADDR_W-1:0] mem_a_out,
   output logic              mem_wr_out,
   output logic [7:0]        mem_dout,
   output logic              rd_we_out,
   output logic [4:0]        rd_addr_out,
   output logic [XLEN-1:0]   rd_val_out,
   output logic              stall_req_out
);

   typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

   state_t            state, state_nx;
   logic [1:0]        cnt, cnt_nx;
   logic [1:0]        k;
   logic [31:0]       asm_q, asm_nx;
   logic [ADDR_W-1:0] a_q, a_nx;
   logic [7:0]        d_q, d_nx;

   logic [1:0]      last;
   logic            size_ok;
   logic            is_ld, is_st, mem_op;
   logic            issue, wr, busy, go;
   logic            we_o;
   logic [XLEN-1:0] val_o, ld_val;

   // last = N-1, the index of the final byte of the access
   always_comb begin
      last    = 2'd0;
      size_ok = 1'b1;
      unique case (funct3_in)
         3'b000, 3'b100: last = 2'd0;
         3'b001, 3'b101: last = 2'd1;
         3'b010:         last = 2'd3;
         default:        size_ok = 1'b0;
      endcase
   end

   // a load wins when both strobes are set
   assign is_ld  = mem_re_in & size_ok;
   assign is_st  = mem_we_in & ~mem_re_in & size_ok;
   assign mem_op = is_ld | is_st;

   always_comb begin
      unique case (funct3_in)
         3'b000:  ld_val = {{(XLEN-8){asm_q[7]}}, asm_q[7:0]};
         3'b001:  ld_val = {{(XLEN-16){asm_q[15]}}, asm_q[15:0]};
         3'b100:  ld_val = {{(XLEN-8){1'b0}}, asm_q[7:0]};
         3'b101:  ld_val = {{(XLEN-16){1'b0}}, asm_q[15:0]};
         default: ld_val = XLEN'(asm_q);
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      asm_nx   = asm_q;
      a_nx     = a_q;
      d_nx     = d_q;
      k        = 2'd0;
      issue    = 1'b0;
      wr       = 1'b0;
      busy     = 1'b0;
      // any memory strobe (even an invalid size) kills the writeback
      we_o     = rd_we_in & ~(mem_re_in | mem_we_in);
      val_o    = rd_val_in;
      unique case (state)
         IDLE: begin
            if (is_ld) begin
               issue    = 1'b1;
               busy     = 1'b1;
               a_nx     = mem_addr_in;
               cnt_nx   = 2'd0;
               state_nx = LOAD;
            end else if (is_st) begin
               issue    = 1'b1;
               wr       = 1'b1;
               busy     = 1'b1;
               a_nx     = mem_addr_in;
               d_nx     = store_data_in[7:0];
               cnt_nx   = 2'd0;
               state_nx = (last == 2'd0) ? DONE : STORE;
            end
         end
         LOAD: begin
            busy = 1'b1;
            we_o = 1'b0;
            asm_nx[{cnt, 3'b000} +: 8] = mem_din;
            if (cnt < last) begin
               k      = cnt + 2'd1;
               issue  = 1'b1;
               a_nx   = mem_addr_in + ADDR_W'(k);
               cnt_nx = k;
            end else begin
               state_nx = DONE;
            end
         end
         STORE: begin
            busy   = 1'b1;
            we_o   = 1'b0;
            k      = cnt + 2'd1;
            issue  = 1'b1;
            wr     = 1'b1;
            a_nx   = mem_addr_in + ADDR_W'(k);
            d_nx   = 8'(store_data_in >> {k, 3'b000});
            cnt_nx = k;
            if (k == last) state_nx = DONE;
         end
         DONE: begin
            we_o     = is_ld & rd_we_in;
            val_o    = is_ld ? ld_val : rd_val_in;
            cnt_nx   = 2'd0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state <= IDLE;
         cnt   <= 2'd0;
         asm_q <= '0;
         a_q   <= '0;
         d_q   <= '0;
      end else if (rdy_in) begin
         state <= state_nx;
         cnt   <= cnt_nx;
         asm_q <= asm_nx;
         a_q   <= a_nx;
         d_q   <= d_nx;
      end
   end

   // the address/data being issued this cycle is presented directly so the
   // RAM samples it at this edge; otherwise the last issued one is held
   assign go         = rst_in & rdy_in;
   assign mem_a_out  = (go & issue) ? a_nx : a_q;
   assign mem_dout   = (go & issue) ? d_nx : d_q;
   assign mem_wr_out = go & wr;

   assign stall_req_out = rst_in &
      (rdy_in ? busy : (mem_op | (state != IDLE)));

   assign rd_we_out   = rst_in & we_o;
   assign rd_addr_out = rst_in ? rd_addr_in : 5'd0;
   assign rd_val_out  = rst_in ? val_o : '0;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access with a byte RAM model.
// Expected results are queued at stimulus time and checked on completion.
module tb_mem_access;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        rd_we_in;
   logic [4:0]  rd_addr_in;
   logic [31:0] rd_val_in;
   logic        mem_re_in, mem_we_in;
   logic [2:0]  funct3_in;
   logic [31:0] mem_addr_in, store_data_in;
   logic [7:0]  mem_din;
   logic [31:0] mem_a_out;
   logic        mem_wr_out;
   logic [7:0]  mem_dout;
   logic        rd_we_out;
   logic [4:0]  rd_addr_out;
   logic [31:0] rd_val_out;
   logic        stall_req_out;

   mem_access dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .rd_we_in(rd_we_in), .rd_addr_in(rd_addr_in),
      .rd_val_in(rd_val_in), .mem_re_in(mem_re_in),
      .mem_we_in(mem_we_in), .funct3_in(funct3_in),
      .mem_addr_in(mem_addr_in), .store_data_in(store_data_in),
      .mem_din(mem_din), .mem_a_out(mem_a_out),
      .mem_wr_out(mem_wr_out), .mem_dout(mem_dout),
      .rd_we_out(rd_we_out), .rd_addr_out(rd_addr_out),
      .rd_val_out(rd_val_out), .stall_req_out(stall_req_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        we;
      logic [31:0] val;
      int          st;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   exp_t sb[$];
   wr_t  exp_wr[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_wr = 0;
   int   n_wr_exp = 0;

   // RAM: preloaded image plus a written overlay, synchronous read
   logic [7:0]    rom [0:1023];
   logic [7:0]    wram [0:1023];
   logic [1023:0] wv = '0;

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
      rom[10'h100] = 8'h78;
      rom[10'h101] = 8'h56;
      rom[10'h102] = 8'h34;
      rom[10'h103] = 8'h12;
      rom[10'h200] = 8'h80;
      rom[10'h203] = 8'hEE;
      rom[10'h204] = 8'h9A;
   end

   always @(posedge clk_in) begin
      mem_din <= wv[mem_a_out[9:0]] ? wram[mem_a_out[9:0]]
                                    : rom[mem_a_out[9:0]];
      if (mem_wr_out) begin
         wram[mem_a_out[9:0]] <= mem_dout;
         wv[mem_a_out[9:0]]   <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h want %08h", tag, got, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (mem_wr_out) begin
         n_wr++;
         if (exp_wr.size() != 0) begin
            wr_t w;
            w = exp_wr.pop_front();
            chk("wr_a", mem_a_out, w.a);
            chk("wr_d", {24'h0, mem_dout}, {24'h0, w.d});
         end
      end
   end

   task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      exp_wr.push_back(w);
      n_wr_exp++;
   endtask

   task automatic run_op(input string tag, input logic re, input logic we,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic ewe,
                         input logic [31:0] ev, input int est,
                         input int nb, input int pz);
      exp_t e;
      int   st, cyc, act;
      bit   fin;
      @(posedge clk_in); #1;
      rd_we_in      = 1'b1;
      rd_addr_in    = 5'd9;
      rd_val_in     = 32'hCAFE_0000;
      mem_re_in     = re;
      mem_we_in     = we;
      funct3_in     = f3;
      mem_addr_in   = a;
      store_data_in = sd;
      e.we  = ewe;
      e.val = ev;
      e.st  = est;
      sb.push_back(e);
      st  = 0;
      cyc = 0;
      act = 0;
      fin = 1'b0;
      while (!fin) begin
         @(negedge clk_in);
         if (!rdy_in)
            chk({tag, ":hold"}, mem_a_out, a + 32'(pz) - 32'd1);
         else if (act < nb)
            chk({tag, ":a"}, mem_a_out, a + 32'(act));
         if (stall_req_out) begin
            st++;
         end else if (rdy_in) begin
            e = sb.pop_front();
            chk({tag, ":we"}, {31'h0, rd_we_out}, {31'h0, e.we});
            if (e.we) begin
               chk({tag, ":val"}, rd_val_out, e.val);
               chk({tag, ":rd"}, {27'h0, rd_addr_out}, 32'd9);
            end
            chk({tag, ":stall"}, st, e.st);
            fin = 1'b1;
         end
         if (rdy_in) act++;
         cyc++;
         if (!fin && cyc > 40) begin
            chk({tag, ":timeout"}, cyc, 0);
            fin = 1'b1;
         end
         if (!fin) begin
            @(posedge clk_in); #1;
            if (pz != 0 && cyc == pz) rdy_in = 1'b0;
            if (pz != 0 && cyc == pz + 3) rdy_in = 1'b1;
         end
      end
      chk({tag, ":wr_n"}, n_wr, n_wr_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no $finish after 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in        = 1'b0;
      rdy_in        = 1'b1;
      rd_we_in      = 1'b1;
      rd_addr_in    = 5'd3;
      rd_val_in     = 32'h55;
      mem_re_in     = 1'b0;
      mem_we_in     = 1'b1;
      funct3_in     = 3'b010;
      mem_addr_in   = 32'h40;
      store_data_in = 32'h1234_5678;

      // reset state with a store pending on the inputs
      @(negedge clk_in);
      chk("rst_wr", {31'h0, mem_wr_out}, 32'd0);
      chk("rst_stall", {31'h0, stall_req_out}, 32'd0);
      chk("rst_we", {31'h0, rd_we_out}, 32'd0);
      chk("rst_rd", {27'h0, rd_addr_out}, 32'd0);
      chk("rst_val", rd_val_out, 32'd0);
      chk("rst_a", mem_a_out, 32'd0);
      chk("rst_d", {24'h0, mem_dout}, 32'd0);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      rst_in    = 1'b1;
      mem_we_in = 1'b0;

      // ALU pass-through
      rd_we_in   = 1'b1;
      rd_addr_in = 5'd5;
      rd_val_in  = 32'h1234;
      @(negedge clk_in);
      chk("pt_we", {31'h0, rd_we_out}, 32'd1);
      chk("pt_rd", {27'h0, rd_addr_out}, 32'd5);
      chk("pt_val", rd_val_out, 32'h1234);
      chk("pt_stall", {31'h0, stall_req_out}, 32'd0);
      chk("pt_wr", {31'h0, mem_wr_out}, 32'd0);

      // loads
      run_op("lw", 1, 0, 3'b010, 32'h100, 0, 1, 32'h1234_5678, 5, 4, 0);
      run_op("lb", 1, 0, 3'b000, 32'h200, 0, 1, 32'hFFFF_FF80, 2, 1, 0);
      run_op("lbu", 1, 0, 3'b100, 32'h200, 0, 1, 32'h0000_0080, 2, 1, 0);
      run_op("lh_mis", 1, 0, 3'b001, 32'h101, 0, 1, 32'h0000_3456, 3, 2, 0);
      run_op("lh_neg", 1, 0, 3'b001, 32'h203, 0, 1, 32'hFFFF_9AEE, 3, 2, 0);
      run_op("lhu", 1, 0, 3'b101, 32'h203, 0, 1, 32'h0000_9AEE, 3, 2, 0);

      // store halfword across the top of the address space
      push_wr(32'hFFFF_FFFF, 8'hEF);
      push_wr(32'h0000_0000, 8'hBE);
      run_op("sh_wrap", 0, 1, 3'b001, 32'hFFFF_FFFF, 32'hABCD_BEEF,
             0, 0, 2, 0, 0);

      // reset in the middle of a store word
      push_wr(32'h300, 8'h44);
      push_wr(32'h301, 8'h33);
      @(posedge clk_in); #1;
      rd_we_in      = 1'b1;
      rd_addr_in    = 5'd7;
      mem_re_in     = 1'b0;
      mem_we_in     = 1'b1;
      funct3_in     = 3'b010;
      mem_addr_in   = 32'h300;
      store_data_in = 32'h1122_3344;
      @(negedge clk_in);
      chk("rsw_stall0", {31'h0, stall_req_out}, 32'd1);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_in);
         chk("rsw_wr", {31'h0, mem_wr_out}, 32'd0);
         chk("rsw_stall", {31'h0, stall_req_out}, 32'd0);
         chk("rsw_we", {31'h0, rd_we_out}, 32'd0);
         @(posedge clk_in); #1;
      end
      rst_in     = 1'b1;
      mem_we_in  = 1'b0;
      rd_addr_in = 5'd12;
      rd_val_in  = 32'h77;
      @(negedge clk_in);
      chk("rsw_idle_stall", {31'h0, stall_req_out}, 32'd0);
      chk("rsw_idle_rd", {27'h0, rd_addr_out}, 32'd12);
      chk("rsw_idle_val", rd_val_out, 32'h77);
      @(negedge clk_in);
      chk("rsw_wr_n", n_wr, n_wr_exp);

      // store word then read it back; store byte
      push_wr(32'h300, 8'hEF);
      push_wr(32'h301, 8'hBE);
      push_wr(32'h302, 8'hAD);
      push_wr(32'h303, 8'hDE);
      run_op("sw", 0, 1, 3'b010, 32'h300, 32'hDEAD_BEEF, 0, 0, 4, 0, 0);
      run_op("lw_back", 1, 0, 3'b010, 32'h300, 0, 1, 32'hDEAD_BEEF, 5, 4, 0);
      push_wr(32'h310, 8'h5A);
      run_op("sb", 0, 1, 3'b000, 32'h310, 32'h1234_565A, 0, 0, 1, 0, 0);
      run_op("lbu_sb", 1, 0, 3'b100, 32'h310, 0, 1, 32'h0000_005A, 2, 1, 0);

      // pause three cycles after byte 1 is issued
      run_op("lw_pause", 1, 0, 3'b010, 32'h100, 0, 1, 32'h1234_5678, 8, 0, 2);

      // load wins over store; invalid size does nothing
      run_op("ld_wins", 1, 1, 3'b010, 32'h100, 32'hFFFF_FFFF,
             1, 32'h1234_5678, 5, 4, 0);
      run_op("bad_f3", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
